// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave in front of a byte-writable block RAM with a
// one-cycle registered read port.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/     AHB-Lite address phase
//   HSIZE/HWRITE/HREADY
//   HWDATA                 AHB-Lite write data (data phase)
//   HREADYOUT/HRDATA/HRESP AHB-Lite slave response
//   ram_addra/dina/wea     RAM write port (word address, data, byte enables)
//   ram_addrb/ram_doutb    RAM read port (data valid the cycle after address)
//
// Build option AHB_BRAM_FWD_EN:
//   defined   - a read that follows a write to the same word gets the
//               write data merged in by byte lane; never stalls.
//   undefined - that read takes one wait state and re-reads the RAM.
module ahb_bram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    localparam int unsigned LANES = 4;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [LANES-1:0]      lane_mask;

    logic                  wr_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LANES-1:0]      mask_q;

    logic                  unused_bits;

    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign haddr_word  = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
    assign HRESP       = 1'b0;

    // Byte lanes touched by the transfer; misaligned low bits are dropped.
    always_comb begin
        lane_mask = 4'b1111;
        case (HSIZE)
            3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
            3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Address-phase capture; held while the bus is not ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            mask_q <= '0;
        end else if (HREADY) begin
            wr_q <= accept & HWRITE;
            rd_q <= accept & ~HWRITE;
            if (accept) begin
                addr_q <= haddr_word;
                mask_q <= lane_mask;
            end
        end
    end

    assign ram_addra = addr_q;
    assign ram_dina  = HWDATA;
    assign ram_wea   = wr_q ? mask_q : 4'b0000;

`ifdef AHB_BRAM_FWD_EN
    logic                  fwd_valid_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [31:0]           fwd_data_q;
    logic [LANES-1:0]      fwd_mask_q;
    logic                  fwd_hit;
    logic [31:0]           rd_merged;

    // Shadow of the last write, valid only in the cycle right after it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            fwd_mask_q  <= '0;
        end else begin
            fwd_valid_q <= wr_q;
            if (wr_q) begin
                fwd_addr_q <= addr_q;
                fwd_data_q <= HWDATA;
                fwd_mask_q <= mask_q;
            end
        end
    end

    assign fwd_hit = fwd_valid_q & (fwd_addr_q == addr_q);

    // RAM returned pre-write data; patch in the freshly written lanes.
    always_comb begin
        rd_merged = ram_doutb;
        for (int n = 0; n < LANES; n++) begin
            if (fwd_hit && fwd_mask_q[n]) begin
                rd_merged[8*n +: 8] = fwd_data_q[8*n +: 8];
            end
        end
    end

    assign HREADYOUT = 1'b1;
    assign ram_addrb = haddr_word;
    assign HRDATA    = rd_q ? rd_merged : 32'h0;
`else
    logic stall_d;
    logic stall_q;

    // Read accepted during a write data phase to the same word.
    assign stall_d = accept & ~HWRITE & wr_q & (haddr_word == addr_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // During the wait state the RAM is re-read now that the write landed.
    assign HREADYOUT = ~stall_q;
    assign ram_addrb = stall_q ? addr_q : haddr_word;
    assign HRDATA    = (rd_q & ~stall_q) ? ram_doutb : 32'h0;
`endif

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave controller that sits directly upstream of the team's byte-writable, registered-read block RAM. It turns AHB-Lite address/data-phase transfers from the Cortex-M0 bus matrix into the RAM's write port (word address, byte strobes, write data) and read port (word address, one-cycle registered data out). It also returns read data to the bus. It resolves the read-after-write hazard caused by the RAM's one-cycle write/read offset, by forwarding or by a wait state selected at compile time.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM word-address width; the RAM holds 2**ADDR_WIDTH 32-bit words.

Ports (one clock, HCLK; reset HRESETn is asynchronous, active-low):
- HCLK  in  1  bus and RAM clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; word index = HADDR[ADDR_WIDTH+1:2]
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are accesses
- HSIZE  in  3  0=byte, 1=halfword, 2=word; other values treated as word
- HWRITE  in  1  1=write
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus ready (previous data phase completes)
- HREADYOUT  out  1  this slave ready
- HRDATA  out  32  read data
- HRESP  out  1  tied 0 (OKAY)
- ram_addra  out  ADDR_WIDTH  RAM write word address
- ram_dina  out  32  RAM write data
- ram_wea  out  4  RAM byte write enables, bit n = byte lane n
- ram_addrb  out  ADDR_WIDTH  RAM read word address
- ram_doutb  in  32  RAM registered read data, valid the cycle after ram_addrb

## Operation
- Accept = HSEL & HTRANS[1] & HREADY. On accept, register: write flag, read flag, word address, and 4-bit lane mask.
- Lane mask: byte = 1<<HADDR[1:0]; halfword = 4'b0011<<{HADDR[1],1'b0}; word = 4'b1111. Misaligned low bits are ignored. No error is raised.
- Write data phase: ram_addra = registered address, ram_dina = HWDATA, ram_wea = lane mask. The RAM commits the write at the closing edge. ram_wea is 0 in all other cycles.
- Read address phase: ram_addrb = HADDR[ADDR_WIDTH+1:2] combinationally, so ram_doutb is valid in the data phase.
- Read data phase: HRDATA = ram_doutb, or the merged data with forwarding. HRDATA = 0 in any cycle that is not a read data phase.
- Hazard: a read accepted in the same cycle as a write data phase to the same word reads the pre-write RAM contents. This is resolved per Configuration.
- IDLE/BUSY transfers, and cycles with HSEL=0, do not touch the RAM and produce no data phase.

## Timing
- Reset (asynchronous): all phase registers clear. HREADYOUT=1, HRDATA=0, ram_wea=0, forward-valid=0, stall state=0. RAM contents are not affected.
- Reads are zero-wait: address phase in cycle N, data on HRDATA in cycle N+1 with HREADYOUT=1.
- Writes are zero-wait: HWDATA is sampled in the data phase, and the RAM is updated at the end of that cycle.
- Back-to-back transfers are sustained at one per cycle, except for the stall case in non-forwarding builds.
- If reset asserts mid-transfer, the pending data phase is dropped. A write whose data phase has not reached its closing edge is not committed.
- If HREADY=0 from another slave, no new transfer is accepted. Registered phase state is held.

## Configuration
- AHB_BRAM_FWD_EN defined:
  - At every write data phase, capture the word address, HWDATA and lane mask into a forward register and set forward-valid.
  - In a read data phase whose address equals the forward address with forward-valid set: HRDATA byte n = forward byte n if the mask bit n is set, otherwise ram_doutb byte n.
  - Forward-valid clears on the next cycle that is not a write data phase. Never stalls.
- Not defined:
  - On the hazard, the read's data phase inserts exactly one wait state (HREADYOUT=0). During that cycle ram_addrb is driven from the registered read address, not HADDR.
  - In the next cycle HREADYOUT=1 with the post-write data.
  - Reads to a different word never stall.

## Test plan
- Reset then idle: HRESETn low for 3 cycles, mid-cycle release -> HREADYOUT=1, HRDATA=0, ram_wea=0 throughout.
- Word write 0x12345678 to 0x0000_0010, later read 0x10 -> ram_addra=4, ram_wea=4'hF; read returns 0x12345678 with zero wait.
- Byte write 0xAB to 0x13, then halfword write 0xCDEF to 0x10, over word 0x00000000 -> a later word read of 0x10 returns 0xAB00CDEF; ram_wea pulses 4'b1000 then 4'b0011.
- Back-to-back word write 0xDEADBEEF to 0x20 then read 0x20 (old contents 0x0):
  - With FWD_EN: HRDATA=0xDEADBEEF, no wait.
  - Without FWD_EN: one HREADYOUT=0 cycle, then 0xDEADBEEF.
- Write then read of a different word (write 0x20, read 0x24) -> no stall in either build; the read returns the old contents of 0x24.
- Reset asserted during a write data phase -> ram_wea deasserts immediately, and a later read of that word returns the old value.
